cp0_exception_unit: RTL and testbench

Memory-stage coprocessor 0 for the 5-stage MIPS pipeline: consumes the per-instruction exception record (BD, VPC, ExcCode) delivered by the E→M pipeline register plus external hardware interrupt lines. It decides whether to take an exception or interrupt this cycle and drives the pipeline-wide `Req` flush that makes every pipeline register load `HANDLE_START`. It holds SR, Cause, EPC and PRId, and serves mtc0, mfc0 and eret.

---
 rtl/cp0_exception_unit.sv | 148 ++++++++++++++
 tb/tb_cp0_exception_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_exception_unit.sv
// cp0_exception_unit
// Memory-stage coprocessor 0 for the 5-stage MIPS pipeline.
// It decides whether to take an exception or interrupt and raises Req to flush the pipeline.
// It holds SR (12), Cause (13), EPC (14) and PRId (15), and serves mtc0, mfc0 and eret.
// Optional feature macro: CP0_TIMER_EN adds Count (9), Compare (11) and the IP7 timer interrupt.
module cp0_exception_unit #(
    parameter logic [31:0] PRID = 32'h0018_0001
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic        M_BD,
    input  logic [31:0] M_VPC,
    input  logic [4:0]  M_ExcCode,
    input  logic [5:0]  HWInt,
    input  logic        M_CP0_WE,
    input  logic [4:0]  M_CP0_Addr,
    input  logic [31:0] M_CP0_WD,
    input  logic        M_eret,
    output logic [31:0] CP0_RD,
    output logic [31:0] EPCOut,
    output logic        Req
);

    localparam logic [4:0] ADDR_COUNT   = 5'd9;
    localparam logic [4:0] ADDR_COMPARE = 5'd11;
    localparam logic [4:0] ADDR_SR      = 5'd12;
    localparam logic [4:0] ADDR_CAUSE   = 5'd13;
    localparam logic [4:0] ADDR_EPC     = 5'd14;
    localparam logic [4:0] ADDR_PRID    = 5'd15;

    // Status register fields
    logic [5:0]  sr_im;
    logic        sr_exl;
    logic        sr_ie;

    // Cause register fields
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;

    logic [31:0] epc;
    logic        timer_ip7;

    logic [5:0]  ip_next;
    logic        int_req;
    logic        exc_req;
    logic        wr_en;
    logic [31:0] sr_value;
    logic [31:0] sr_wd;
    logic [31:0] cause_value;
    logic [31:0] epc_target;

    assign ip_next     = {timer_ip7 | HWInt[5], HWInt[4:0]};
    assign int_req     = (|(ip_next & sr_im)) & sr_ie & ~sr_exl;
    assign exc_req     = (M_ExcCode != 5'd0) & ~sr_exl;
    assign Req         = int_req | exc_req;
    assign wr_en       = M_CP0_WE & ~Req;

    assign sr_value    = {16'b0, sr_im, 8'b0, sr_exl, sr_ie};
    assign sr_wd       = {16'b0, M_CP0_WD[15:10], 8'b0, M_CP0_WD[1:0]};
    assign cause_value = {cause_bd, 15'b0, cause_ip, 3'b0, cause_exc, 2'b0};
    assign epc_target  = M_BD ? (M_VPC - 32'd4) : M_VPC;

`ifdef CP0_TIMER_EN
    logic [31:0] count;
    logic [31:0] compare;
    logic [31:0] count_next;

    assign count_next = (wr_en && M_CP0_Addr == ADDR_COUNT) ? M_CP0_WD : count + 32'd1;

    // Free-running Count, writable Compare, and the IP7 match flag (a Compare write clears it)
    always_ff @(posedge clk) begin
        if (RESET) begin
            count     <= 32'd0;
            compare   <= 32'd0;
            timer_ip7 <= 1'b0;
        end else begin
            count <= count_next;
            if (wr_en && M_CP0_Addr == ADDR_COMPARE) begin
                compare   <= M_CP0_WD;
                timer_ip7 <= 1'b0;
            end else if (count_next == compare && compare != 32'd0) begin
                timer_ip7 <= 1'b1;
            end
        end
    end
`else
    assign timer_ip7 = 1'b0;
`endif

    // mfc0 read mux; a same-cycle mtc0 to the addressed register is forwarded
    always_comb begin
        CP0_RD = 32'd0;
        case (M_CP0_Addr)
            ADDR_SR:      CP0_RD = M_CP0_WE ? sr_wd : sr_value;
            ADDR_CAUSE:   CP0_RD = cause_value;
            ADDR_EPC:     CP0_RD = M_CP0_WE ? M_CP0_WD : epc;
            ADDR_PRID:    CP0_RD = PRID;
`ifdef CP0_TIMER_EN
            ADDR_COUNT:   CP0_RD = M_CP0_WE ? M_CP0_WD : count;
            ADDR_COMPARE: CP0_RD = M_CP0_WE ? M_CP0_WD : compare;
`endif
            default:      CP0_RD = 32'd0;
        endcase
    end

    // eret target, forwarding a same-cycle mtc0 to EPC
    always_comb begin
        EPCOut = epc;
        if (M_CP0_WE && M_CP0_Addr == ADDR_EPC) begin
            EPCOut = M_CP0_WD;
        end
    end

    // Architectural state: exception entry has priority over mtc0/eret in the same cycle
    always_ff @(posedge clk) begin
        if (RESET) begin
            sr_im     <= 6'd0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= 6'd0;
            cause_exc <= 5'd0;
            epc       <= 32'd0;
        end else begin
            cause_ip <= ip_next;
            if (Req) begin
                sr_exl    <= 1'b1;
                cause_bd  <= M_BD;
                cause_exc <= int_req ? 5'd0 : M_ExcCode;
                epc       <= epc_target;
            end else begin
                if (wr_en && M_CP0_Addr == ADDR_SR) begin
                    sr_im  <= M_CP0_WD[15:10];
                    sr_exl <= M_CP0_WD[1];
                    sr_ie  <= M_CP0_WD[0];
                end
                if (wr_en && M_CP0_Addr == ADDR_EPC) begin
                    epc <= M_CP0_WD;
                end
                if (M_eret) begin
                    sr_exl <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cp0_exception_unit.sv
// Directed self-checking bench for cp0_exception_unit.
// The timer section runs only when CP0_TIMER_EN is defined.
module tb_cp0_exception_unit;

    logic        clk = 1'b0;
    logic        RESET;
    logic        M_BD;
    logic [31:0] M_VPC;
    logic [4:0]  M_ExcCode;
    logic [5:0]  HWInt;
    logic        M_CP0_WE;
    logic [4:0]  M_CP0_Addr;
    logic [31:0] M_CP0_WD;
    logic        M_eret;
    logic [31:0] CP0_RD;
    logic [31:0] EPCOut;
    logic        Req;

    int checks = 0;
    int errors = 0;

    cp0_exception_unit dut (
        .clk        (clk),
        .RESET      (RESET),
        .M_BD       (M_BD),
        .M_VPC      (M_VPC),
        .M_ExcCode  (M_ExcCode),
        .HWInt      (HWInt),
        .M_CP0_WE   (M_CP0_WE),
        .M_CP0_Addr (M_CP0_Addr),
        .M_CP0_WD   (M_CP0_WD),
        .M_eret     (M_eret),
        .CP0_RD     (CP0_RD),
        .EPCOut     (EPCOut),
        .Req        (Req)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic idle();
        M_BD       = 1'b0;
        M_VPC      = 32'd0;
        M_ExcCode  = 5'd0;
        HWInt      = 6'd0;
        M_CP0_WE   = 1'b0;
        M_CP0_Addr = 5'd0;
        M_CP0_WD   = 32'd0;
        M_eret     = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_reg(input string tag, input logic [4:0] addr, input logic [31:0] expected);
        M_CP0_Addr = addr;
        #1;
        check(tag, CP0_RD, expected);
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        M_CP0_WE   = 1'b1;
        M_CP0_Addr = addr;
        M_CP0_WD   = data;
        tick();
        idle();
    endtask

    task automatic eret();
        M_eret = 1'b1;
        tick();
        idle();
    endtask

    initial begin
        RESET = 1'b1;
        idle();
        tick();
        tick();
        RESET = 1'b0;

        // Reset state
        read_reg("rst_sr", 5'd12, 32'h0000_0000);
        check("rst_req", {31'd0, Req}, 32'd0);
        read_reg("rst_cause", 5'd13, 32'h0000_0000);
        read_reg("rst_epc", 5'd14, 32'h0000_0000);
        read_reg("rst_prid", 5'd15, 32'h0018_0001);
        check("rst_epcout", EPCOut, 32'h0000_0000);
        read_reg("other_reg", 5'd3, 32'h0000_0000);
`ifndef CP0_TIMER_EN
        read_reg("rst_count", 5'd9, 32'h0000_0000);
`endif

        // Exception in a branch delay slot
        M_ExcCode = 5'd10; M_BD = 1'b1; M_VPC = 32'h0000_3010;
        #1 check("ds_req", {31'd0, Req}, 32'd1);
        tick();
        idle();
        read_reg("ds_epc", 5'd14, 32'h0000_300C);
        read_reg("ds_cause", 5'd13, 32'h8000_0028);
        read_reg("ds_sr_exl", 5'd12, 32'h0000_0002);
        check("ds_epcout", EPCOut, 32'h0000_300C);

        // EXL masks both exceptions and interrupts; nested exception is lost
        M_ExcCode = 5'd4; HWInt = 6'h3F; M_VPC = 32'h0000_9999;
        #1 check("exl_req", {31'd0, Req}, 32'd0);
        tick();
        idle();
        read_reg("exl_epc_kept", 5'd14, 32'h0000_300C);

        // mtc0 EPC then eret
        M_CP0_WE = 1'b1; M_CP0_Addr = 5'd14; M_CP0_WD = 32'h0000_3020;
        #1 check("mtc0_epc_bypass", EPCOut, 32'h0000_3020);
        tick();
        idle();
        M_eret = 1'b1;
        #1 check("eret_epcout", EPCOut, 32'h0000_3020);
        tick();
        idle();
        read_reg("eret_sr", 5'd12, 32'h0000_0000);

        // Same-cycle mfc0 bypass
        M_CP0_WE = 1'b1; M_CP0_Addr = 5'd14; M_CP0_WD = 32'h0000_3040;
        #1 check("mfc0_bypass", CP0_RD, 32'h0000_3040);
        tick();
        idle();
        read_reg("epc_written", 5'd14, 32'h0000_3040);

        // Interrupt beats simultaneous exception
        mtc0(5'd12, 32'h0000_0401);
        HWInt = 6'b000001; M_ExcCode = 5'd4; M_VPC = 32'h0000_4000;
        #1 check("int_req", {31'd0, Req}, 32'd1);
        tick();
        idle();
        read_reg("int_cause", 5'd13, 32'h0000_0400);
        read_reg("int_sr", 5'd12, 32'h0000_0403);
        read_reg("int_epc", 5'd14, 32'h0000_4000);
        eret();
        read_reg("int_eret_sr", 5'd12, 32'h0000_0401);

        // IE=0: interrupt blocked, exception still taken
        mtc0(5'd12, 32'h0000_0400);
        HWInt = 6'b000001;
        #1 check("ie0_int_req", {31'd0, Req}, 32'd0);
        M_ExcCode = 5'd4; M_VPC = 32'h0000_5000;
        #1 check("ie0_exc_req", {31'd0, Req}, 32'd1);
        tick();
        idle();
        read_reg("ie0_cause", 5'd13, 32'h0000_0410);
        eret();

        // IM masking: line 0 masked, line 5 enabled
        mtc0(5'd12, 32'h0000_8001);
        HWInt = 6'b000001;
        #1 check("im_masked_req", {31'd0, Req}, 32'd0);
        HWInt = 6'b100000; M_VPC = 32'h0000_7000;
        #1 check("im5_req", {31'd0, Req}, 32'd1);
        tick();
        idle();
        read_reg("im5_cause", 5'd13, 32'h0000_8000);
        eret();
        mtc0(5'd12, 32'h0000_0000);

        // EPC wraps when subtracting 4 in a delay slot
        M_ExcCode = 5'd12; M_BD = 1'b1; M_VPC = 32'h0000_0002;
        tick();
        idle();
        read_reg("wrap_epc", 5'd14, 32'hFFFF_FFFE);
        read_reg("wrap_cause", 5'd13, 32'h8000_0030);
        eret();

        // mtc0 suppressed during a Req cycle
        M_ExcCode = 5'd3; M_VPC = 32'h0000_6000;
        M_CP0_WE = 1'b1; M_CP0_Addr = 5'd14; M_CP0_WD = 32'hDEAD_0000;
        #1 check("sup_req", {31'd0, Req}, 32'd1);
        tick();
        idle();
        read_reg("sup_epc", 5'd14, 32'h0000_6000);
        read_reg("sup_sr", 5'd12, 32'h0000_0002);
        eret();

        // Cause is read-only; SR keeps only defined bits
        mtc0(5'd13, 32'hFFFF_FFFF);
        read_reg("cause_ro", 5'd13, 32'h0000_000C);
        mtc0(5'd12, 32'hFFFF_FFFF);
        read_reg("sr_mask", 5'd12, 32'h0000_FC03);
        HWInt = 6'h3F;
        #1 check("sr_exl_req", {31'd0, Req}, 32'd0);
        idle();
        eret();

`ifdef CP0_TIMER_EN
        // Timer match raises IP7 and, with IM[15]/IE set, an interrupt
        begin
            logic seen;
            seen = 1'b0;
            mtc0(5'd12, 32'h0000_8001);
            mtc0(5'd11, 32'd5);
            mtc0(5'd9, 32'd0);
            for (int i = 0; i < 12; i++) begin
                #1;
                if (Req) begin
                    seen = 1'b1;
                    break;
                end
                tick();
            end
            check("timer_req", {31'd0, seen}, 32'd1);
            tick();
            read_reg("timer_ip7", 5'd13, 32'h0000_8000);
            mtc0(5'd11, 32'd1000);
            tick();
            read_reg("timer_clear", 5'd13, 32'h0000_0000);
            eret();
            mtc0(5'd12, 32'h0000_0000);
        end
`else
        // Without the timer, Count/Compare do not exist
        mtc0(5'd9, 32'h0000_0123);
        tick();
        read_reg("no_count", 5'd9, 32'h0000_0000);
        mtc0(5'd11, 32'h0000_0005);
        read_reg("no_compare", 5'd11, 32'h0000_0000);
`endif

        // Reset overrides a coincident Req
        mtc0(5'd14, 32'h0000_1234);
        RESET = 1'b1; M_ExcCode = 5'd5; M_VPC = 32'h0000_8000; HWInt = 6'b000001;
        #1 check("rst_req_hi", {31'd0, Req}, 32'd1);
        tick();
        RESET = 1'b0;
        idle();
        read_reg("rst2_sr", 5'd12, 32'h0000_0000);
        read_reg("rst2_epc", 5'd14, 32'h0000_0000);
        read_reg("rst2_cause", 5'd13, 32'h0000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
